mul8_share_sched: RTL and testbench

- Schedules one shared 8-bit shift-add multiplier datapath between two requesters, each presenting an 8-bit operand pair (a, b).
- Arbitrates round-robin, sequences the multiplier through WIDTH iterations, and returns a 16-bit product tagged with the requester id.
- Returns results over a valid/ready handshake.
- Sits between the operand sources (data_a/data_b style 8-bit streams) and the downstream result consumer.

---
 rtl/mul8_share_sched_pkg.sv | 28 ++
 rtl/mul8_share_sched_dp.sv | 69 ++++++
 rtl/mul8_share_sched.sv | 140 ++++++++++++++
 tb/tb_mul8_share_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mul8_share_sched_pkg.sv
// Shared definitions for the two-requester shared shift-add multiplier scheduler.
// Holds the default operand width, the requester count, the scheduler state
// encoding and the round-robin grant helper used by the top level.
package mul8_share_sched_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int NUM_REQ       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // One-hot grant for two requesters. A lone valid requester always wins;
  // when both are valid the priority pointer (0 = requester 0) decides.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic ptr);
    logic [1:0] grant;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/mul8_share_sched_dp.sv
// Shift-add multiplier datapath shared by both requesters.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   load          capture a/b, clear accumulator and iteration counter
//   step          perform one add-and-shift iteration
//   a, b          multiplicand / multiplier operands
//   product       {accumulator, multiplier} chain; the full product after WIDTH steps
//   last          high while the counter is on the final iteration
module mul8_shift_add_dp
  import mul8_share_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   sum_s;

  // Conditional add of the multiplicand into the upper half, keeping the carry.
  always_comb begin
    sum_s = {1'b0, acc_r};
    if (mplier_r[0]) begin
      sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r};
    end
  end

  // Operand capture and the {carry, acc, multiplier} right-shift per iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (load) begin
      mcand_r  <= a;
      acc_r    <= {WIDTH{1'b0}};
      mplier_r <= b;
      cnt_r    <= {CW{1'b0}};
    end else if (step) begin
      acc_r    <= sum_s[WIDTH:1];
      mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CW'(1);
    end else begin
      mcand_r  <= mcand_r;
      acc_r    <= acc_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

  assign product = {acc_r, mplier_r};
  assign last    = (cnt_r == CW'(WIDTH - 1));

endmodule

// File: rtl/mul8_share_sched.sv
// Round-robin scheduler that shares one shift-add multiplier between two
// requesters and returns id-tagged products over a valid/ready handshake.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_req_valid    per-requester operand valid (bit k = requester k)
//   i_req_a/b      packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready    one-hot accept strobe (combinational, IDLE only)
//   o_res_valid    product available
//   o_res          product a*b
//   o_res_id       requester owning o_res
//   i_res_ready    consumer accepts the result
//   o_busy         high while calculating or holding a result
module mul8_share_sched
  import mul8_share_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_res_valid,
  output logic [2*WIDTH-1:0]       o_res,
  output logic                     o_res_id,
  input  logic                     i_res_ready,
  output logic                     o_busy
);

  sched_state_e     state_r;
  sched_state_e     state_next_s;
  logic             ptr_r;
  logic             id_r;
  logic             res_valid_r;
  logic             busy_r;
  logic [1:0]       grant_s;
  logic             dp_load_s;
  logic             dp_step_s;
  logic             dp_last_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  // Next-state, grant and datapath control.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 2'b00;
    dp_load_s    = 1'b0;
    dp_step_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Grant is suppressed during reset so ready reads 0 immediately.
        if (i_rst) begin
          grant_s = 2'b00;
        end else begin
          grant_s = rr_grant(i_req_valid, ptr_r);
        end
        if (grant_s != 2'b00) begin
          dp_load_s    = 1'b1;
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        dp_step_s = 1'b1;
        if (dp_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (i_res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s = i_req_a[0 +: WIDTH];
    sel_b_s = i_req_b[0 +: WIDTH];
    if (grant_s[1]) begin
      sel_a_s = i_req_a[WIDTH +: WIDTH];
      sel_b_s = i_req_b[WIDTH +: WIDTH];
    end else begin
      sel_a_s = i_req_a[0 +: WIDTH];
      sel_b_s = i_req_b[0 +: WIDTH];
    end
  end

  // State, pointer, owner id and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 1'b0;
      id_r        <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      res_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
      // Pointer moves only on an accept, always to the requester not granted.
      if (dp_load_s) begin
        id_r  <= grant_s[1];
        ptr_r <= ~grant_s[1];
      end else begin
        id_r  <= id_r;
        ptr_r <= ptr_r;
      end
    end
  end

  mul8_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (dp_load_s),
    .step    (dp_step_s),
    .a       (sel_a_s),
    .b       (sel_b_s),
    .product (o_res),
    .last    (dp_last_s)
  );

  assign o_req_ready = grant_s;
  assign o_res_valid = res_valid_r;
  assign o_res_id    = id_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_mul8_share_sched.sv
// Self-checking bench for mul8_share_sched: a transaction-level model checks
// every cycle, directed sequences pin literal results, then random traffic.
module tb_mul8_share_sched;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]    req_ready;
  logic          res_valid;
  logic [2*W-1:0] res;
  logic          res_id;
  logic          res_ready;
  logic          busy;

  int checks;
  int failures;

  // model: m_t = edges since accept (-1 when idle), result valid at m_t == W
  int m_t;
  int m_a;
  int m_b;
  int m_id;
  int m_ptr;
  int gid;
  logic [1:0] g_exp;

  mul8_share_sched #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_res_valid (res_valid),
    .o_res       (res),
    .o_res_id    (res_id),
    .i_res_ready (res_ready),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle model compare (inputs are stable between posedge+2 and next posedge)
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res", int'(res), 0);
      chk("rst_res_id", int'(res_id), 0);
      chk("rst_busy", int'(busy), 0);
      m_t = -1;
      m_ptr = 0;
    end else if (m_t < 0) begin
      gid = (req_valid == 2'b11) ? m_ptr : (req_valid[1] ? 1 : 0);
      g_exp = (req_valid == 2'b00) ? 2'b00 : (2'b01 << gid);
      chk("m_idle_ready", int'(req_ready), int'(g_exp));
      chk("m_idle_busy", int'(busy), 0);
      chk("m_idle_valid", int'(res_valid), 0);
      if (g_exp != 2'b00) begin
        m_t = 0;
        m_a = int'(req_a[gid*W +: W]);
        m_b = int'(req_b[gid*W +: W]);
        m_id = gid;
        m_ptr = 1 - gid;
      end
    end else begin
      chk("m_busy_ready", int'(req_ready), 0);
      chk("m_busy", int'(busy), 1);
      chk("m_res_valid", int'(res_valid), (m_t == W) ? 1 : 0);
      if (m_t == W) begin
        chk("m_res", int'(res), m_a * m_b);
        chk("m_res_id", int'(res_id), m_id);
        if (res_ready) m_t = -1;
      end else begin
        m_t++;
      end
    end
  end

  // One transaction from requester id; holds the result for stall cycles.
  task automatic run_txn(input int id, input int a, input int b, input int stall,
                         input int exp_prod);
    int bc;
    int lat;
    int held;
    @(posedge clk); #2;
    req_valid = 2'b01 << id;
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
    res_ready = (stall == 0);
    #1;
    chk("txn_grant", int'(req_ready), 1 << id);
    @(posedge clk); #2;
    // withdraw, or (when stalling) present both requesters: neither may be granted
    req_valid = (stall > 0) ? 2'b11 : 2'b00;
    bc = 0; lat = -1; held = 0;
    while (busy && bc < 60) begin
      chk("txn_no_grant_busy", int'(req_ready), 0);
      if (res_valid) begin
        if (lat < 0) begin
          lat = bc;
          chk("txn_res_id", int'(res_id), id);
        end
        chk("txn_res", int'(res), exp_prod);
        if (held < stall) held++;
        else res_ready = 1'b1;
      end
      bc++;
      @(posedge clk); #2;
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    chk("txn_latency", lat, W);
    chk("txn_busy_cycles", bc, W + 1 + stall);
    chk("txn_valid_dropped", int'(res_valid), 0);
  endtask

  initial begin
    int exp_res[4];
    int exp_id[4];
    int cyc;
    int seen;
    checks = 0; failures = 0;
    m_t = -1; m_ptr = 0; m_a = 0; m_b = 0; m_id = 0;
    rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run_txn(0, 1, 200, 0, 200);
    run_txn(1, 34, 100, 0, 3400);

    // both valid continuously: 0,1,0,1 starting with requester 0
    exp_res = '{15, 77, 15, 77};
    exp_id  = '{0, 1, 0, 1};
    @(posedge clk); #2;
    req_a = {8'd7, 8'd3}; req_b = {8'd11, 8'd5}; req_valid = 2'b11; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!res_valid && cyc < 40) begin
        @(posedge clk); #2; cyc++;
      end
      chk("alt_timeout", int'(res_valid), 1);
      chk("alt_res", int'(res), exp_res[k]);
      chk("alt_id", int'(res_id), exp_id[k]);
      @(posedge clk); #2;
    end
    req_valid = 2'b00;

    run_txn(0, 255, 255, 5, 65025);
    run_txn(0, 0, 173, 0, 0);
    run_txn(0, 173, 0, 0, 0);

    // mid-operation reset
    @(posedge clk); #2;
    req_valid = 2'b01; req_a[7:0] = 8'd9; req_b[7:0] = 8'd9;
    @(posedge clk); #2;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_valid", int'(res_valid), 0);
    chk("mrst_res", int'(res), 0);
    @(posedge clk); #2 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (res_valid) seen++;
    end
    chk("mrst_no_result", seen, 0);
    run_txn(1, 12, 13, 0, 156);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      req_valid = 2'($urandom_range(0, 3));
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0; req_valid = 2'b00; res_ready = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    chk("end_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
